lock_supervisor: RTL and testbench
==================================

Name: lock_supervisor

Overview:
- Sequencing controller that sits between the keypad and the code-check engine.
- Gates key presses into code-entry sessions, starts the engine, collects its verdict and drives the unlock window.
- Counts consecutive failures and enforces a timed lockout with alarm; all timers are in clock cycles.

Parameters:
- CODE_LEN, 4: digits per entry session.
- MAX_FAIL, 3: consecutive failures that trigger lockout (2..7).
- UNLOCK_CYC, 8: cycles `unlocked` stays high after a match.
- LOCKOUT_CYC, 16: cycles spent in lockout.
- TIMEOUT_CYC, 12: idle cycles allowed between digits, and wait cycles allowed for the verdict.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe, key press present.
- key  in  4  key code; 4'hF = clear key, all others are digits.
- chk_done  in  1  one-cycle strobe from engine, verdict valid.
- chk_match  in  1  engine verdict, sampled only when chk_done=1.
- chk_start  out  1  one-cycle pulse, begin new comparison.
- chk_digit  out  4  digit forwarded to engine.
- chk_digit_valid  out  1  one-cycle strobe qualifying chk_digit.
- unlocked  out  1  door open.
- alarm  out  1  buzzer drive.
- locked_out  out  1  lockout active.
- fail_cnt  out  3  consecutive failure count.
- state  out  3  current FSM state (debug).

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - state=IDLE(0).
  - All outputs 0; fail_cnt=0; digit and timer counters 0.
  - A session in progress is discarded.
- All outputs are registered; a response appears on the edge after the qualifying input.
- State encoding: IDLE=0, ENTRY=1, WAIT=2, OPEN=3, FAIL=4, LOCKOUT=5. Encodings 6 and 7 go to IDLE.
- IDLE:
  - key_valid with a digit → ENTRY. Next cycle: chk_start=1, chk_digit_valid=1, chk_digit=key, digit count=1.
  - Clear key in IDLE is ignored.
- ENTRY, digit key: forwarded with chk_digit_valid for 1 cycle and digit count increments; the timer is cleared. When the count reaches CODE_LEN → WAIT, timer cleared.
- ENTRY, clear key: abort → IDLE. Digit count 0; fail_cnt unchanged; no chk_digit_valid.
- ENTRY, no key for TIMEOUT_CYC consecutive cycles: abort → IDLE, same as clear key.
- WAIT:
  - Key presses are ignored.
  - chk_done with chk_match=1 → OPEN; fail_cnt cleared.
  - chk_done with chk_match=0 → FAIL.
  - No chk_done within TIMEOUT_CYC cycles → FAIL.
  - chk_done outside WAIT is ignored.
- OPEN:
  - unlocked=1 for exactly UNLOCK_CYC cycles, then → IDLE with unlocked=0.
  - Keys are ignored.
- FAIL (one cycle):
  - alarm=1 for this cycle; fail_cnt increments.
  - If the incremented value equals MAX_FAIL → LOCKOUT; else → IDLE.
- LOCKOUT:
  - locked_out=1 and alarm=1 for exactly LOCKOUT_CYC cycles; keys are ignored.
  - On exit → IDLE with fail_cnt=0, locked_out=0, alarm=0.
- fail_cnt saturates at MAX_FAIL and never wraps.
- Simultaneous events:
  - key_valid on the same cycle as a timer expiry in ENTRY: the key wins and the timer restarts.
  - chk_done on the same cycle as the WAIT timeout: the verdict wins.
- chk_start and chk_digit_valid are never asserted outside the first IDLE→ENTRY cycle and ENTRY digit cycles.

Test Plan:
- Reset → key_valid with 4'h1, 4'h2, 4'h3, 4'h4 on alternate cycles → chk_start is a 1-cycle pulse with the first digit; 4 chk_digit_valid strobes; state=WAIT. Then chk_done=1, chk_match=1 → unlocked high 8 cycles, then state=IDLE.
- Three sessions each answered chk_match=0 → alarm is a 1-cycle pulse after the 1st and 2nd failures; fail_cnt 1, 2. After the 3rd: locked_out=1 and alarm=1 for 16 cycles; keys during lockout produce no chk_* activity; exit with fail_cnt=0.
- Enter 2 digits then key 4'hF → state=IDLE, fail_cnt unchanged, no further chk_digit_valid. Enter 2 digits then idle 12 cycles → state=IDLE, fail_cnt unchanged.
- Full 4-digit entry with no chk_done for 12 cycles → FAIL: fail_cnt=1, alarm pulse.
- Start a session, fail once (fail_cnt=1), then a matching session → fail_cnt=0.
- Pulse reset low for 1 ns mid-ENTRY and mid-LOCKOUT → all outputs 0 immediately (asynchronous), state=IDLE.

Source files
------------

// File: rtl/lock_supervisor.sv
// Keypad session sequencer: gates digits into the code-check engine, collects its
// verdict, drives the unlock window and enforces a timed lockout after repeated failures.
module lock_supervisor #(
   parameter int CODE_LEN    = 4,
   parameter int MAX_FAIL    = 3,
   parameter int UNLOCK_CYC  = 8,
   parameter int LOCKOUT_CYC = 16,
   parameter int TIMEOUT_CYC = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key,
   input  logic       chk_done,
   input  logic       chk_match,
   output logic       chk_start,
   output logic [3:0] chk_digit,
   output logic       chk_digit_valid,
   output logic       unlocked,
   output logic       alarm,
   output logic       locked_out,
   output logic [2:0] fail_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_WAIT    = 3'd2,
      S_OPEN    = 3'd3,
      S_FAIL    = 3'd4,
      S_LOCKOUT = 3'd5
   } state_t;

   localparam int TMAX_A = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int TMAX   = (TMAX_A > TIMEOUT_CYC) ? TMAX_A : TIMEOUT_CYC;
   localparam int TW     = $clog2(TMAX + 1);
   localparam int DW     = $clog2(CODE_LEN + 1);

   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] UN_LAST  = TW'(UNLOCK_CYC - 1);
   localparam logic [TW-1:0] LO_LAST  = TW'(LOCKOUT_CYC - 1);
   localparam logic [DW-1:0] D_LAST   = DW'(CODE_LEN);
   localparam logic [2:0]    FAIL_MAX = 3'(MAX_FAIL);

   state_t          r_state, w_state;
   logic [TW-1:0]   r_timer, w_timer;
   logic [DW-1:0]   r_digit_cnt, w_digit_cnt;
   logic [2:0]      r_fail_cnt, w_fail_cnt;
   logic            r_chk_start, w_chk_start;
   logic [3:0]      r_chk_digit, w_chk_digit;
   logic            r_chk_digit_valid, w_chk_digit_valid;
   logic            r_unlocked, w_unlocked;
   logic            r_alarm, w_alarm;
   logic            r_locked_out, w_locked_out;

   logic            w_key_digit;
   logic            w_key_clear;
   logic [2:0]      w_fail_inc;
   logic [DW-1:0]   w_digit_next;

   assign w_key_digit  = key_valid && (key != 4'hF);
   assign w_key_clear  = key_valid && (key == 4'hF);
   assign w_fail_inc   = (r_fail_cnt >= FAIL_MAX) ? FAIL_MAX : r_fail_cnt + 3'd1;
   assign w_digit_next = r_digit_cnt + DW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state           <= S_IDLE;
         r_timer           <= '0;
         r_digit_cnt       <= '0;
         r_fail_cnt        <= '0;
         r_chk_start       <= 1'b0;
         r_chk_digit       <= '0;
         r_chk_digit_valid <= 1'b0;
         r_unlocked        <= 1'b0;
         r_alarm           <= 1'b0;
         r_locked_out      <= 1'b0;
      end else begin
         r_state           <= w_state;
         r_timer           <= w_timer;
         r_digit_cnt       <= w_digit_cnt;
         r_fail_cnt        <= w_fail_cnt;
         r_chk_start       <= w_chk_start;
         r_chk_digit       <= w_chk_digit;
         r_chk_digit_valid <= w_chk_digit_valid;
         r_unlocked        <= w_unlocked;
         r_alarm           <= w_alarm;
         r_locked_out      <= w_locked_out;
      end
   end

   // Outputs are computed as next-state values so every port comes straight from a flop.
   always_comb begin
      w_state           = r_state;
      w_timer           = r_timer;
      w_digit_cnt       = r_digit_cnt;
      w_fail_cnt        = r_fail_cnt;
      w_chk_start       = 1'b0;
      w_chk_digit       = r_chk_digit;
      w_chk_digit_valid = 1'b0;
      w_unlocked        = 1'b0;
      w_alarm           = 1'b0;
      w_locked_out      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_key_digit) begin
               w_state           = (CODE_LEN == 1) ? S_WAIT : S_ENTRY;
               w_chk_start       = 1'b1;
               w_chk_digit_valid = 1'b1;
               w_chk_digit       = key;
               w_digit_cnt       = DW'(1);
               w_timer           = '0;
            end
         end
         S_ENTRY: begin
            if (w_key_digit) begin
               w_chk_digit_valid = 1'b1;
               w_chk_digit       = key;
               w_digit_cnt       = w_digit_next;
               w_timer           = '0;
               if (w_digit_next == D_LAST) begin
                  w_state = S_WAIT;
               end
            end else if (w_key_clear || (r_timer == TO_LAST)) begin
               w_state     = S_IDLE;
               w_digit_cnt = '0;
               w_timer     = '0;
            end else begin
               w_timer = r_timer + TW'(1);
            end
         end
         S_WAIT: begin
            if (chk_done && chk_match) begin
               w_state    = S_OPEN;
               w_fail_cnt = '0;
               w_unlocked = 1'b1;
               w_timer    = '0;
            end else if (chk_done || (r_timer == TO_LAST)) begin
               w_state    = S_FAIL;
               w_fail_cnt = w_fail_inc;
               w_alarm    = 1'b1;
               w_timer    = '0;
            end else begin
               w_timer = r_timer + TW'(1);
            end
         end
         S_OPEN: begin
            if (r_timer == UN_LAST) begin
               w_state = S_IDLE;
               w_timer = '0;
            end else begin
               w_timer    = r_timer + TW'(1);
               w_unlocked = 1'b1;
            end
         end
         S_FAIL: begin
            // fail_cnt already holds the incremented value during this cycle.
            w_timer = '0;
            if (r_fail_cnt == FAIL_MAX) begin
               w_state      = S_LOCKOUT;
               w_locked_out = 1'b1;
               w_alarm      = 1'b1;
            end else begin
               w_state = S_IDLE;
            end
         end
         S_LOCKOUT: begin
            if (r_timer == LO_LAST) begin
               w_state    = S_IDLE;
               w_fail_cnt = '0;
               w_timer    = '0;
            end else begin
               w_timer      = r_timer + TW'(1);
               w_locked_out = 1'b1;
               w_alarm      = 1'b1;
            end
         end
         default: begin
            w_state     = S_IDLE;
            w_timer     = '0;
            w_digit_cnt = '0;
         end
      endcase
   end

   assign chk_start       = r_chk_start;
   assign chk_digit       = r_chk_digit;
   assign chk_digit_valid = r_chk_digit_valid;
   assign unlocked        = r_unlocked;
   assign alarm           = r_alarm;
   assign locked_out      = r_locked_out;
   assign fail_cnt        = r_fail_cnt;
   assign state           = r_state;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed self-checking bench for lock_supervisor: sessions, verdicts, aborts,
// timeouts, lockout and asynchronous reset, each in its own task.
module tb_lock_supervisor;

   logic       clk;
   logic       reset;
   logic       keyValid;
   logic [3:0] key;
   logic       chkDone;
   logic       chkMatch;
   logic       chkStart;
   logic [3:0] chkDigit;
   logic       chkDigitValid;
   logic       unlocked;
   logic       alarm;
   logic       lockedOut;
   logic [2:0] failCnt;
   logic [2:0] state;
   logic [14:0] allOut;

   int checks = 0;
   int errors = 0;

   lock_supervisor dut (
      .clk             (clk),
      .reset           (reset),
      .key_valid       (keyValid),
      .key             (key),
      .chk_done        (chkDone),
      .chk_match       (chkMatch),
      .chk_start       (chkStart),
      .chk_digit       (chkDigit),
      .chk_digit_valid (chkDigitValid),
      .unlocked        (unlocked),
      .alarm           (alarm),
      .locked_out      (lockedOut),
      .fail_cnt        (failCnt),
      .state           (state)
   );

   assign allOut = {state, chkStart, chkDigitValid, chkDigit, unlocked, alarm, lockedOut, failCnt};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // Stimulus helpers: inputs change 1 ns after the rising edge, outputs are sampled there too.
   task tick;
      @(posedge clk);
      #1;
   endtask

   task sendKey(input logic [3:0] k);
      keyValid = 1'b1;
      key      = k;
      tick();
      keyValid = 1'b0;
   endtask

   task enterCode(input logic [15:0] code);
      for (int i = 3; i >= 0; i--) begin
         sendKey(code[i*4 +: 4]);
         if (i != 0) tick();
      end
   endtask

   task verdict(input logic m);
      chkDone  = 1'b1;
      chkMatch = m;
      tick();
      chkDone  = 1'b0;
      chkMatch = 1'b0;
   endtask

   task test_reset;
      reset    = 1'b0;
      keyValid = 1'b0;
      key      = 4'h0;
      chkDone  = 1'b0;
      chkMatch = 1'b0;
      #12;
      checks++;
      if (allOut !== 15'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h required %h", allOut, 15'd0);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_idle: state got %0d required 0", state);
      end
   endtask

   task test_basic_unlock;
      int strobes;
      int starts;
      int hiCycles;
      strobes = 0;
      starts  = 0;
      for (int i = 0; i < 4; i++) begin
         sendKey(4'(i + 1));
         strobes += int'(chkDigitValid);
         starts  += int'(chkStart);
         checks++;
         if ({chkStart, chkDigitValid, chkDigit} !== {(i == 0), 1'b1, 4'(i + 1)}) begin
            errors++;
            $display("[TB] FAIL basic_digit%0d: start/valid/digit got %b/%b/%h required %b/1/%h",
                     i, chkStart, chkDigitValid, chkDigit, (i == 0), 4'(i + 1));
         end
         if (i < 3) begin
            tick();
            strobes += int'(chkDigitValid);
            starts  += int'(chkStart);
         end
      end
      checks++;
      if (state !== 3'd2) begin
         errors++;
         $display("[TB] FAIL basic_wait: state got %0d required 2", state);
      end
      checks++;
      if (strobes !== 4 || starts !== 1) begin
         errors++;
         $display("[TB] FAIL basic_strobes: valid/start got %0d/%0d required 4/1", strobes, starts);
      end
      tick();
      verdict(1'b1);
      checks++;
      if (state !== 3'd3 || unlocked !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_open: state/unlocked got %0d/%b required 3/1", state, unlocked);
      end
      hiCycles = 1;
      for (int j = 1; j < 8; j++) begin
         tick();
         hiCycles += int'(unlocked);
      end
      checks++;
      if (hiCycles !== 8) begin
         errors++;
         $display("[TB] FAIL basic_unlock_len: got %0d cycles required 8", hiCycles);
      end
      tick();
      checks++;
      if (state !== 3'd0 || unlocked !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_close: state/unlocked got %0d/%b required 0/0", state, unlocked);
      end
   endtask

   task test_wait_timeout;
      enterCode(16'h5678);
      repeat (11) tick();
      checks++;
      if (state !== 3'd2) begin
         errors++;
         $display("[TB] FAIL wait_before_timeout: state got %0d required 2", state);
      end
      tick();
      checks++;
      if ({state, alarm, failCnt} !== {3'd4, 1'b1, 3'd1}) begin
         errors++;
         $display("[TB] FAIL wait_timeout_fail: state/alarm/fail got %0d/%b/%0d required 4/1/1",
                  state, alarm, failCnt);
      end
      tick();
      checks++;
      if ({state, alarm, failCnt} !== {3'd0, 1'b0, 3'd1}) begin
         errors++;
         $display("[TB] FAIL wait_timeout_idle: state/alarm/fail got %0d/%b/%0d required 0/0/1",
                  state, alarm, failCnt);
      end
   endtask

   task test_clear_abort;
      int strobes;
      sendKey(4'h1);
      tick();
      sendKey(4'h2);
      tick();
      sendKey(4'hF);
      checks++;
      if ({state, chkDigitValid, failCnt} !== {3'd0, 1'b0, 3'd1}) begin
         errors++;
         $display("[TB] FAIL clear_abort: state/valid/fail got %0d/%b/%0d required 0/0/1",
                  state, chkDigitValid, failCnt);
      end
      strobes = 0;
      repeat (3) begin
         tick();
         strobes += int'(chkDigitValid);
      end
      checks++;
      if (strobes !== 0) begin
         errors++;
         $display("[TB] FAIL clear_quiet: strobes got %0d required 0", strobes);
      end
   endtask

   task test_idle_timeout;
      sendKey(4'h7);
      tick();
      sendKey(4'h8);
      repeat (11) tick();
      checks++;
      if (state !== 3'd1) begin
         errors++;
         $display("[TB] FAIL idle_before_timeout: state got %0d required 1", state);
      end
      tick();
      checks++;
      if ({state, failCnt} !== {3'd0, 3'd1}) begin
         errors++;
         $display("[TB] FAIL idle_timeout: state/fail got %0d/%0d required 0/1", state, failCnt);
      end
      sendKey(4'h9);
      repeat (11) tick();
      sendKey(4'h3);
      checks++;
      if ({state, chkDigitValid, chkDigit} !== {3'd1, 1'b1, 4'h3}) begin
         errors++;
         $display("[TB] FAIL key_wins_timeout: state/valid/digit got %0d/%b/%h required 1/1/3",
                  state, chkDigitValid, chkDigit);
      end
      sendKey(4'hF);
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("[TB] FAIL key_wins_abort: state got %0d required 0", state);
      end
   endtask

   task test_fail_then_match;
      enterCode(16'h1111);
      verdict(1'b0);
      checks++;
      if ({state, alarm, failCnt} !== {3'd4, 1'b1, 3'd2}) begin
         errors++;
         $display("[TB] FAIL ftm_fail: state/alarm/fail got %0d/%b/%0d required 4/1/2",
                  state, alarm, failCnt);
      end
      tick();
      enterCode(16'h1234);
      verdict(1'b1);
      checks++;
      if ({state, unlocked, failCnt} !== {3'd3, 1'b1, 3'd0}) begin
         errors++;
         $display("[TB] FAIL ftm_match: state/unlocked/fail got %0d/%b/%0d required 3/1/0",
                  state, unlocked, failCnt);
      end
      repeat (8) tick();
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("[TB] FAIL ftm_idle: state got %0d required 0", state);
      end
   endtask

   task test_lockout;
      int activity;
      int lockHi;
      for (int n = 1; n <= 3; n++) begin
         enterCode(16'h9999);
         verdict(1'b0);
         checks++;
         if ({state, alarm, failCnt} !== {3'd4, 1'b1, 3'(n)}) begin
            errors++;
            $display("[TB] FAIL lock_fail%0d: state/alarm/fail got %0d/%b/%0d required 4/1/%0d",
                     n, state, alarm, failCnt, n);
         end
         tick();
         if (n < 3) begin
            checks++;
            if ({state, alarm} !== {3'd0, 1'b0}) begin
               errors++;
               $display("[TB] FAIL lock_pulse%0d: state/alarm got %0d/%b required 0/0", n, state, alarm);
            end
         end
      end
      checks++;
      if ({state, lockedOut, alarm, failCnt} !== {3'd5, 1'b1, 1'b1, 3'd3}) begin
         errors++;
         $display("[TB] FAIL lock_enter: state/locked/alarm/fail got %0d/%b/%b/%0d required 5/1/1/3",
                  state, lockedOut, alarm, failCnt);
      end
      activity = 0;
      lockHi   = 1;
      for (int j = 1; j < 16; j++) begin
         keyValid = j[0];
         key      = 4'(j);
         tick();
         keyValid = 1'b0;
         activity += int'(chkStart | chkDigitValid);
         lockHi   += int'(lockedOut & alarm);
      end
      checks++;
      if (activity !== 0 || lockHi !== 16) begin
         errors++;
         $display("[TB] FAIL lock_hold: activity/cycles got %0d/%0d required 0/16", activity, lockHi);
      end
      tick();
      checks++;
      if ({state, lockedOut, alarm, failCnt} !== {3'd0, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("[TB] FAIL lock_exit: state/locked/alarm/fail got %0d/%b/%b/%0d required 0/0/0/0",
                  state, lockedOut, alarm, failCnt);
      end
   endtask

   task test_async_reset;
      sendKey(4'h3);
      checks++;
      if ({state, chkStart} !== {3'd1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL areset_pre_entry: state/start got %0d/%b required 1/1", state, chkStart);
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (allOut !== 15'd0) begin
         errors++;
         $display("[TB] FAIL areset_entry: got %h required %h", allOut, 15'd0);
      end
      reset = 1'b1;
      tick();
      for (int n = 0; n < 3; n++) begin
         enterCode(16'h4444);
         verdict(1'b0);
         tick();
      end
      repeat (4) tick();
      checks++;
      if ({state, lockedOut} !== {3'd5, 1'b1}) begin
         errors++;
         $display("[TB] FAIL areset_pre_lock: state/locked got %0d/%b required 5/1", state, lockedOut);
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (allOut !== 15'd0) begin
         errors++;
         $display("[TB] FAIL areset_lockout: got %h required %h", allOut, 15'd0);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (allOut !== 15'd0) begin
         errors++;
         $display("[TB] FAIL areset_after: got %h required %h", allOut, 15'd0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_unlock();
      test_wait_timeout();
      test_clear_abort();
      test_idle_timeout();
      test_fail_then_match();
      test_lockout();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
